// File: rtl/regbank_pkg.sv
// Shared types and helpers for the multi-port register bank.
// Holds the sweep FSM encoding and packed-port slicing helpers.
package regbank_pkg;

  typedef enum logic {
    CLEAR = 1'b0,
    RUN   = 1'b1
  } state_e;

  function automatic int aw_of(input int n);
    return $clog2(n);
  endfunction

  function automatic int lsb_of(input int k, input int w);
    return k * w;
  endfunction

endpackage

// File: rtl/regbank_scoreboard.sv
// Pending bits for in-flight producers of the register bank.
// Writes clear a bit before reserves set it, so a new producer wins.
module regbank_scoreboard
  import regbank_pkg::*;
#(
  parameter int REG_COUNT = 32,
  parameter int AW        = 5,
  parameter int NUM_RD    = 2,
  parameter int NUM_WR    = 1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 en,
  input  logic [NUM_WR-1:0]    wr_en,
  input  logic [NUM_WR*AW-1:0] wr_addr,
  input  logic                 rsv_en,
  input  logic [AW-1:0]        rsv_addr,
  input  logic [NUM_RD*AW-1:0] rd_addr,
  output logic [NUM_RD-1:0]    rd_busy
);

  logic [REG_COUNT-1:0] pend_q;
  logic [REG_COUNT-1:0] pend_d;

  // Clear on write first, then set on reserve.
  always_comb begin
    pend_d = pend_q;
    if (en) begin
      for (int j = 0; j < NUM_WR; j++) begin
        if (wr_en[j]) begin
          pend_d[wr_addr[lsb_of(j, AW) +: AW]] = 1'b0;
        end
      end
      if (rsv_en && rsv_addr != '0) begin
        pend_d[rsv_addr] = 1'b1;
      end
    end
  end

  // Pending state, wiped on reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      pend_q <= '0;
    end else begin
      pend_q <= pend_d;
    end
  end

  // Busy unless a same-cycle write is retiring the producer.
  always_comb begin
    logic [AW-1:0] ra;
    logic          hit;
    rd_busy = '0;
    for (int k = 0; k < NUM_RD; k++) begin
      ra  = rd_addr[lsb_of(k, AW) +: AW];
      hit = 1'b0;
      for (int j = 0; j < NUM_WR; j++) begin
        if (wr_en[j] && wr_addr[lsb_of(j, AW) +: AW] == ra) begin
          hit = 1'b1;
        end
      end
      rd_busy[k] = en & pend_q[ra] & ~hit & (ra != '0);
    end
  end

endmodule

// File: rtl/regbank_mp.sv
// Multi-port integer register bank with bypass and scoreboard.
// A post-reset sweep zeroes x1..xN-1 before ready rises.
module regbank_mp
  import regbank_pkg::*;
#(
  parameter  int XLEN      = 32,
  parameter  int REG_COUNT = 32,
  parameter  int NUM_RD    = 2,
  parameter  int NUM_WR    = 1,
  localparam int AW        = aw_of(REG_COUNT)
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [NUM_RD*AW-1:0]   rd_addr,
  output logic [NUM_RD*XLEN-1:0] rd_data,
  output logic [NUM_RD-1:0]      rd_busy,
  input  logic [NUM_WR-1:0]      wr_en,
  input  logic [NUM_WR*AW-1:0]   wr_addr,
  input  logic [NUM_WR*XLEN-1:0] wr_data,
  input  logic                   rsv_en,
  input  logic [AW-1:0]          rsv_addr,
  output logic                   ready
);

  state_e          state_q;
  state_e          state_d;
  logic [AW-1:0]   clr_ptr_q;
  logic [AW-1:0]   clr_ptr_d;
  logic            ready_q;
  logic [XLEN-1:0] mem_q [REG_COUNT];
  logic [XLEN-1:0] mem_d [REG_COUNT];
  logic            active;

  assign active = (state_q == RUN) & ~rst;
  assign ready  = ready_q & ~rst;

  // Next array and FSM: sweep in CLEAR, arbitrated writes in RUN.
  always_comb begin
    mem_d     = mem_q;
    state_d   = state_q;
    clr_ptr_d = clr_ptr_q;
    if (state_q == CLEAR) begin
      mem_d[clr_ptr_q] = '0;
      clr_ptr_d        = clr_ptr_q + AW'(1);
      if (clr_ptr_q == AW'(REG_COUNT - 1)) begin
        state_d = RUN;
      end
    end else begin
      for (int j = 0; j < NUM_WR; j++) begin
        if (wr_en[j] && wr_addr[lsb_of(j, AW) +: AW] != '0) begin
          mem_d[wr_addr[lsb_of(j, AW) +: AW]] =
            wr_data[lsb_of(j, XLEN) +: XLEN];
        end
      end
    end
  end

  // FSM, sweep pointer and registered ready.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= CLEAR;
      clr_ptr_q <= AW'(1);
      ready_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      clr_ptr_q <= clr_ptr_d;
      ready_q   <= (state_d == RUN);
    end
  end

  // Array storage; anything presented during reset is dropped.
  always_ff @(posedge clk) begin
    if (!rst) begin
      mem_q <= mem_d;
    end
  end

  // Read muxes with highest-port write bypass and hardwired x0.
  always_comb begin
    logic [AW-1:0]   ra;
    logic [XLEN-1:0] rv;
    rd_data = '0;
    for (int k = 0; k < NUM_RD; k++) begin
      ra = rd_addr[lsb_of(k, AW) +: AW];
      rv = mem_q[ra];
      for (int j = 0; j < NUM_WR; j++) begin
        if (wr_en[j] && wr_addr[lsb_of(j, AW) +: AW] == ra) begin
          rv = wr_data[lsb_of(j, XLEN) +: XLEN];
        end
      end
      if (active && ra != '0) begin
        rd_data[lsb_of(k, XLEN) +: XLEN] = rv;
      end
    end
  end

  regbank_scoreboard #(
    .REG_COUNT (REG_COUNT),
    .AW        (AW),
    .NUM_RD    (NUM_RD),
    .NUM_WR    (NUM_WR)
  ) u_sb (
    .clk      (clk),
    .rst      (rst),
    .en       (active),
    .wr_en    (wr_en),
    .wr_addr  (wr_addr),
    .rsv_en   (rsv_en),
    .rsv_addr (rsv_addr),
    .rd_addr  (rd_addr),
    .rd_busy  (rd_busy)
  );

endmodule

// File: tb/tb_regbank_mp.sv
// Scoreboard bench for regbank_mp: two configurations share stimulus.
// A queue of expected outputs is drained by an independent monitor.
module tb_regbank_mp;

  localparam int A_RC = 32, A_NRD = 2, A_NWR = 2, A_X = 32, A_AW = 5;
  localparam int B_RC = 16, B_NRD = 3, B_NWR = 2, B_X = 64, B_AW = 4;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst;

  logic [A_NRD*A_AW-1:0] a_rd_addr;
  logic [A_NRD*A_X-1:0]  a_rd_data;
  logic [A_NRD-1:0]      a_rd_busy;
  logic [A_NWR-1:0]      a_wr_en;
  logic [A_NWR*A_AW-1:0] a_wr_addr;
  logic [A_NWR*A_X-1:0]  a_wr_data;
  logic                  a_rsv_en;
  logic [A_AW-1:0]       a_rsv_addr;
  logic                  a_ready;

  logic [B_NRD*B_AW-1:0] b_rd_addr;
  logic [B_NRD*B_X-1:0]  b_rd_data;
  logic [B_NRD-1:0]      b_rd_busy;
  logic [B_NWR-1:0]      b_wr_en;
  logic [B_NWR*B_AW-1:0] b_wr_addr;
  logic [B_NWR*B_X-1:0]  b_wr_data;
  logic                  b_rsv_en;
  logic [B_AW-1:0]       b_rsv_addr;
  logic                  b_ready;

  regbank_mp #(
    .XLEN(A_X), .REG_COUNT(A_RC), .NUM_RD(A_NRD), .NUM_WR(A_NWR)
  ) dut_a (
    .clk(clk), .rst(rst),
    .rd_addr(a_rd_addr), .rd_data(a_rd_data), .rd_busy(a_rd_busy),
    .wr_en(a_wr_en), .wr_addr(a_wr_addr), .wr_data(a_wr_data),
    .rsv_en(a_rsv_en), .rsv_addr(a_rsv_addr), .ready(a_ready)
  );

  regbank_mp #(
    .XLEN(B_X), .REG_COUNT(B_RC), .NUM_RD(B_NRD), .NUM_WR(B_NWR)
  ) dut_b (
    .clk(clk), .rst(rst),
    .rd_addr(b_rd_addr), .rd_data(b_rd_data), .rd_busy(b_rd_busy),
    .wr_en(b_wr_en), .wr_addr(b_wr_addr), .wr_data(b_wr_data),
    .rsv_en(b_rsv_en), .rsv_addr(b_rsv_addr), .ready(b_ready)
  );

  // stimulus shared by both instances (addresses masked per instance)
  logic        s_rst;
  logic [4:0]  s_ra [3];
  logic        s_we [2];
  logic [4:0]  s_wa [2];
  logic [63:0] s_wd [2];
  logic        s_rsv;
  logic [4:0]  s_rsva;

  // reference model: architectural contents, pending set, sweep countdown
  logic [63:0] m_mem  [2][32];
  logic        m_pend [2][32];
  int          m_left [2];

  typedef struct {
    logic [1:0][2:0][63:0] data;
    logic [1:0][2:0]       busy;
    logic [1:0]            rdy;
    int                    cyc;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   errors = 0;
  int   ncyc   = 0;

  task automatic model_inst(input int i,
                            output logic [2:0][63:0] od,
                            output logic [2:0] ob,
                            output logic orr);
    int          rc;
    int          nrd;
    logic [4:0]  am;
    logic [63:0] dm;
    logic [4:0]  a;
    logic [4:0]  wa;
    logic [63:0] v;
    logic        hit;
    rc  = (i == 1) ? B_RC : A_RC;
    nrd = (i == 1) ? B_NRD : A_NRD;
    am  = (i == 1) ? 5'h0f : 5'h1f;
    dm  = (i == 1) ? 64'hffff_ffff_ffff_ffff : 64'h0000_0000_ffff_ffff;
    od  = '0;
    ob  = '0;
    orr = 1'b0;
    if (s_rst) begin
      m_left[i] = rc - 1;
      for (int r = 0; r < 32; r++) begin
        m_mem[i][r]  = '0;
        m_pend[i][r] = 1'b0;
      end
      return;
    end
    if (m_left[i] > 0) begin
      m_left[i]--;
      return;
    end
    orr = 1'b1;
    for (int k = 0; k < nrd; k++) begin
      a   = s_ra[k] & am;
      v   = m_mem[i][a];
      hit = 1'b0;
      for (int j = 0; j < 2; j++) begin
        if (s_we[j] && (s_wa[j] & am) == a) begin
          hit = 1'b1;
          v   = s_wd[j] & dm;
        end
      end
      if (a != 0) begin
        od[k] = v;
        ob[k] = m_pend[i][a] && !hit;
      end
    end
    for (int j = 0; j < 2; j++) begin
      wa = s_wa[j] & am;
      if (s_we[j] && wa != 0) m_mem[i][wa] = s_wd[j] & dm;
    end
    for (int j = 0; j < 2; j++) begin
      if (s_we[j]) m_pend[i][s_wa[j] & am] = 1'b0;
    end
    if (s_rsv && (s_rsva & am) != 0) m_pend[i][s_rsva & am] = 1'b1;
  endtask

  task automatic step();
    exp_t              e;
    logic [2:0][63:0]  od;
    logic [2:0]        ob;
    logic              orr;
    @(negedge clk);
    rst = s_rst;
    for (int k = 0; k < A_NRD; k++) a_rd_addr[k*A_AW +: A_AW] = s_ra[k];
    for (int k = 0; k < B_NRD; k++) b_rd_addr[k*B_AW +: B_AW] = s_ra[k][3:0];
    for (int j = 0; j < 2; j++) begin
      a_wr_en[j]               = s_we[j];
      a_wr_addr[j*A_AW +: A_AW] = s_wa[j];
      a_wr_data[j*A_X +: A_X]  = s_wd[j][31:0];
      b_wr_en[j]               = s_we[j];
      b_wr_addr[j*B_AW +: B_AW] = s_wa[j][3:0];
      b_wr_data[j*B_X +: B_X]  = s_wd[j];
    end
    a_rsv_en   = s_rsv;
    a_rsv_addr = s_rsva;
    b_rsv_en   = s_rsv;
    b_rsv_addr = s_rsva[3:0];
    model_inst(0, od, ob, orr);
    e.data[0] = od;
    e.busy[0] = ob;
    e.rdy[0]  = orr;
    model_inst(1, od, ob, orr);
    e.data[1] = od;
    e.busy[1] = ob;
    e.rdy[1]  = orr;
    e.cyc     = ncyc;
    ncyc++;
    exp_q.push_back(e);
  endtask

  task automatic idle();
    s_rst = 1'b0;
    s_rsv = 1'b0;
    s_rsva = '0;
    for (int j = 0; j < 2; j++) begin
      s_we[j] = 1'b0;
      s_wa[j] = '0;
      s_wd[j] = '0;
    end
  endtask

  // monitor: pops one expectation per cycle and compares settled outputs
  initial begin
    exp_t        e;
    logic [63:0] act;
    logic        ab;
    logic        ar;
    int          nrd;
    forever begin
      @(negedge clk);
      #2;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        for (int i = 0; i < 2; i++) begin
          ar = (i == 1) ? b_ready : a_ready;
          checks++;
          if (ar !== e.rdy[i]) begin
            errors++;
            $display("FAIL ready inst%0d cyc%0d got %0b want %0b",
                     i, e.cyc, ar, e.rdy[i]);
          end
          nrd = (i == 1) ? B_NRD : A_NRD;
          for (int k = 0; k < nrd; k++) begin
            if (i == 1) begin
              act = b_rd_data[k*B_X +: B_X];
              ab  = b_rd_busy[k];
            end else begin
              act = {32'h0, a_rd_data[k*A_X +: A_X]};
              ab  = a_rd_busy[k];
            end
            checks++;
            if (act !== e.data[i][k]) begin
              errors++;
              $display("FAIL rd_data inst%0d port%0d cyc%0d got %h want %h",
                       i, k, e.cyc, act, e.data[i][k]);
            end
            checks++;
            if (ab !== e.busy[i][k]) begin
              errors++;
              $display("FAIL rd_busy inst%0d port%0d cyc%0d got %0b want %0b",
                       i, k, e.cyc, ab, e.busy[i][k]);
            end
          end
        end
      end
    end
  end

  initial begin
    logic [4:0] wa;
    for (int k = 0; k < 3; k++) s_ra[k] = '0;
    idle();

    // reset pulse then sweep, with ignored writes while clearing
    s_rst = 1'b1;
    step();
    s_rst = 1'b0;
    for (int c = 0; c < 35; c++) begin
      for (int k = 0; k < 3; k++) s_ra[k] = 5'($urandom_range(0, 31));
      for (int j = 0; j < 2; j++) begin
        s_we[j] = (c < 31) && ($urandom_range(0, 1) == 1);
        s_wa[j] = 5'($urandom_range(1, 31));
        s_wd[j] = {$urandom, $urandom};
      end
      s_rsv  = (c < 31);
      s_rsva = 5'($urandom_range(1, 31));
      step();
    end
    idle();
    for (int r = 0; r < 32; r += 2) begin
      s_ra[0] = 5'(r);
      s_ra[1] = 5'(r + 1);
      s_ra[2] = 5'(31 - r);
      step();
    end

    // write with same-cycle bypass, then array read, then x0
    s_we[0] = 1'b1; s_wa[0] = 5'd5; s_wd[0] = 64'hDEADBEEF;
    s_ra[0] = 5'd5; s_ra[1] = 5'd0; s_ra[2] = 5'd5;
    step();
    idle();
    step();
    s_we[0] = 1'b1; s_wa[0] = 5'd0; s_wd[0] = 64'h1234;
    s_ra[0] = 5'd0; s_ra[1] = 5'd0; s_ra[2] = 5'd0;
    step();
    idle();
    step();

    // write collision on x7: higher port wins
    s_we[0] = 1'b1; s_wa[0] = 5'd7; s_wd[0] = 64'h11;
    s_we[1] = 1'b1; s_wa[1] = 5'd7; s_wd[1] = 64'h22;
    s_ra[0] = 5'd7; s_ra[1] = 5'd7; s_ra[2] = 5'd7;
    step();
    idle();
    step();

    // scoreboard reserve / write / both / x0
    s_ra[0] = 5'd3; s_ra[1] = 5'd3; s_ra[2] = 5'd0;
    s_rsv = 1'b1; s_rsva = 5'd3;
    step();
    idle();
    step();
    s_we[0] = 1'b1; s_wa[0] = 5'd3; s_wd[0] = 64'h33;
    step();
    idle();
    step();
    s_we[1] = 1'b1; s_wa[1] = 5'd3; s_wd[1] = 64'h44;
    s_rsv = 1'b1; s_rsva = 5'd3;
    step();
    idle();
    step();
    s_ra[0] = 5'd0;
    s_rsv = 1'b1; s_rsva = 5'd0;
    step();
    idle();
    step();

    // mid-run reset while writing x9
    s_ra[0] = 5'd9; s_ra[1] = 5'd9; s_ra[2] = 5'd9;
    s_we[0] = 1'b1; s_wa[0] = 5'd9; s_wd[0] = 64'hA5;
    s_rsv = 1'b1; s_rsva = 5'd9;
    step();
    idle();
    step();
    s_rst = 1'b1;
    s_we[0] = 1'b1; s_wa[0] = 5'd9; s_wd[0] = 64'hFF;
    step();
    idle();
    for (int c = 0; c < 36; c++) begin
      for (int j = 0; j < 2; j++) begin
        wa = 5'($urandom_range(1, 31));
        if (wa[3:0] == 4'd9) wa = wa ^ 5'd1;
        s_we[j] = (c < 31);
        s_wa[j] = wa;
        s_wd[j] = {$urandom, $urandom};
      end
      step();
    end
    idle();

    // randomized traffic with narrow address windows for hits
    for (int c = 0; c < 600; c++) begin
      s_rst = ($urandom_range(0, 249) == 0);
      for (int k = 0; k < 3; k++) begin
        s_ra[k] = ($urandom_range(0, 1) == 1) ?
                  5'($urandom_range(0, 7)) : 5'($urandom_range(0, 31));
      end
      for (int j = 0; j < 2; j++) begin
        s_we[j] = ($urandom_range(0, 2) != 0);
        s_wa[j] = ($urandom_range(0, 1) == 1) ?
                  5'($urandom_range(0, 7)) : 5'($urandom_range(0, 31));
        s_wd[j] = {$urandom, $urandom};
      end
      s_rsv  = ($urandom_range(0, 1) == 1);
      s_rsva = 5'($urandom_range(0, 7));
      step();
    end
    idle();
    step();

    for (int t = 0; t < 10 && exp_q.size() > 0; t++) @(negedge clk);
    #5;
    if (exp_q.size() > 0) begin
      errors++;
      $display("FAIL drain got %0d pending want 0", exp_q.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
